// File: rtl/multiplexor_de_displays.sv
// Time-multiplexed driver for three 7-segment displays, refreshed from a 150 Hz scan clock.
// Each frame is latched on entry to slot D0 so every display in a scan shows the same snapshot.
module multiplexor_de_displays #(
    parameter int BLINK_HALF = 75
) (
    input  logic       clockInt_150Hz,
    input  logic       reset,
    input  logic [3:0] digito0,
    input  logic [3:0] digito1,
    input  logic [3:0] digito2,
    input  logic [2:0] parpadeo,
    output logic [2:0] anodos,
    output logic [6:0] segmentos,
    output logic       finBarrido
);

    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2
    } slot_e;

    // state_q names the slot that the next clock edge will put on the outputs
    slot_e          state_q, state_d;
    logic [3:0]     frame1_q, frame2_q;
    logic [2:0]     frame_par_q;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           phase_q, phase_d;

    logic [2:0]     anodos_d;
    logic [6:0]     segmentos_d;
    logic           fin_d;
    logic [3:0]     digit;
    logic           blink_en;

    // ---------------- ring counter: state register ----------------
    always_ff @(posedge clockInt_150Hz) begin
        if (reset) begin
            state_q <= D0;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- ring counter: next state ----------------
    always_comb begin
        state_d = D0;
        case (state_q)
            D0:      state_d = D1;
            D1:      state_d = D2;
            D2:      state_d = D0;
            default: state_d = D0;
        endcase
    end

    // ---------------- output decode (registered below) ----------------
    always_comb begin
        anodos_d = 3'b111;
        digit    = 4'hF;
        blink_en = 1'b0;
        fin_d    = 1'b0;
        case (state_q)
            D0: begin
                // D0 shows the inputs being captured on this very edge
                anodos_d = 3'b110;
                digit    = digito0;
                blink_en = parpadeo[0];
            end
            D1: begin
                anodos_d = 3'b101;
                digit    = frame1_q;
                blink_en = frame_par_q[1];
            end
            D2: begin
                anodos_d = 3'b011;
                digit    = frame2_q;
                blink_en = frame_par_q[2];
                fin_d    = 1'b1;
            end
            default: begin
                anodos_d = 3'b111;
                digit    = 4'hF;
                blink_en = 1'b1;
            end
        endcase
    end

    always_comb begin
        segmentos_d = 7'b1111111;
        if (!(phase_q && blink_en)) begin
            case (digit)
                4'd0:    segmentos_d = 7'b0000001;
                4'd1:    segmentos_d = 7'b1001111;
                4'd2:    segmentos_d = 7'b0010010;
                4'd3:    segmentos_d = 7'b0000110;
                4'd4:    segmentos_d = 7'b1001100;
                4'd5:    segmentos_d = 7'b0100100;
                4'd6:    segmentos_d = 7'b0100000;
                4'd7:    segmentos_d = 7'b0001111;
                4'd8:    segmentos_d = 7'b0000000;
                4'd9:    segmentos_d = 7'b0000100;
                default: segmentos_d = 7'b1111111;
            endcase
        end
    end

    // ---------------- blink timebase ----------------
    always_comb begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
        if (cnt_q == BLINK_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clockInt_150Hz) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // ---------------- frame snapshot ----------------
    always_ff @(posedge clockInt_150Hz) begin
        if (reset) begin
            frame1_q    <= '0;
            frame2_q    <= '0;
            frame_par_q <= '0;
        end else if (state_q == D0) begin
            frame1_q    <= digito1;
            frame2_q    <= digito2;
            frame_par_q <= parpadeo;
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clockInt_150Hz) begin
        if (reset) begin
            anodos     <= 3'b111;
            segmentos  <= 7'b1111111;
            finBarrido <= 1'b0;
        end else begin
            anodos     <= anodos_d;
            segmentos  <= segmentos_d;
            finBarrido <= fin_d;
        end
    end

endmodule

// File: tb/tb_multiplexor_de_displays.sv
// Bench for multiplexor_de_displays: table vectors, hand-written corner sequences and
// randomized traffic, all checked against an edge-count based reference model.
module tb_multiplexor_de_displays;

    localparam int BH = 75;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] d0, d1, d2;
    logic [2:0] par;
    logic [2:0] an;
    logic [6:0] seg;
    logic       fin;

    always #5 clk = ~clk;

    multiplexor_de_displays #(.BLINK_HALF(BH)) dut (
        .clockInt_150Hz(clk),
        .reset         (reset),
        .digito0       (d0),
        .digito1       (d1),
        .digito2       (d2),
        .parpadeo      (par),
        .anodos        (an),
        .segmentos     (seg),
        .finBarrido    (fin)
    );

    int checks = 0;
    int errors = 0;

    // reference model state: edges since reset release and the latched frame
    int         n_m;
    logic [3:0] f1_m, f2_m;
    logic [2:0] fp_m;

    function automatic logic [6:0] dec(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100,
              7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
        return t[v];
    endfunction

    task automatic chk(input string name, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: an/seg/fin got %b_%b_%b want %b_%b_%b", name,
                     got[10:8], got[7:1], got[0], exp[10:8], exp[7:1], exp[0]);
        end
    endtask

    // one clock edge; model predicts, DUT is sampled 1 time unit after the edge
    task automatic tick(input string name);
        logic [2:0] ea;
        logic [6:0] es;
        logic       ef;
        logic [3:0] v;
        logic       b;
        int         idx;
        if (reset) begin
            n_m = 0; f1_m = '0; f2_m = '0; fp_m = '0;
            ea = 3'b111; es = 7'b1111111; ef = 1'b0;
        end else begin
            n_m++;
            idx = (n_m - 1) % 3;
            if (idx == 0) begin
                f1_m = d1; f2_m = d2; fp_m = par;
                v = d0; b = par[0];
            end else if (idx == 1) begin
                v = f1_m; b = fp_m[1];
            end else begin
                v = f2_m; b = fp_m[2];
            end
            ea = 3'b111;
            ea[idx] = 1'b0;
            es = ((((n_m - 1) / BH) % 2) == 1 && b) ? 7'b1111111 : dec(v);
            ef = (idx == 2);
        end
        @(posedge clk);
        #1;
        chk(name, {an, seg, fin}, {ea, es, ef});
    endtask

    typedef struct {
        logic [3:0] v0, v1, v2;
        logic [2:0] p;
        logic [6:0] s0, s1, s2;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{4'd1, 4'd2, 4'd3, 3'b000, 7'b1001111, 7'b0010010, 7'b0000110};
        tbl[1] = '{4'd4, 4'd5, 4'd6, 3'b111, 7'b1001100, 7'b0100100, 7'b0100000};
        tbl[2] = '{4'd7, 4'd8, 4'd9, 3'b000, 7'b0001111, 7'b0000000, 7'b0000100};
        tbl[3] = '{4'd0, 4'd12, 4'd15, 3'b000, 7'b0000001, 7'b1111111, 7'b1111111};
        tbl[4] = '{4'd10, 4'd11, 4'd13, 3'b010, 7'b1111111, 7'b1111111, 7'b1111111};

        reset = 1'b1; d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; par = 3'b000;
        n_m = 0; f1_m = '0; f2_m = '0; fp_m = '0;
        #2;

        // reset held two edges
        tick("reset0");
        tick("reset1");
        reset = 1'b0;

        // table vectors, one full frame each, all within blink phase 0
        for (int i = 0; i < 5; i++) begin
            d0 = tbl[i].v0; d1 = tbl[i].v1; d2 = tbl[i].v2; par = tbl[i].p;
            tick("tbl_model");
            chk($sformatf("tbl%0d_d0", i), {an, seg, fin}, {3'b110, tbl[i].s0, 1'b0});
            tick("tbl_model");
            chk($sformatf("tbl%0d_d1", i), {an, seg, fin}, {3'b101, tbl[i].s1, 1'b0});
            tick("tbl_model");
            chk($sformatf("tbl%0d_d2", i), {an, seg, fin}, {3'b011, tbl[i].s2, 1'b1});
        end

        // mid-frame change of digito1 must wait for the next D0
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; par = 3'b000;
        tick("mid_d0");
        d1 = 4'd7;
        tick("mid_d1");
        chk("mid_old_d1", {an, seg, fin}, {3'b101, 7'b0010010, 1'b0});
        tick("mid_d2");
        tick("mid_d0b");
        tick("mid_d1b");
        chk("mid_new_d1", {an, seg, fin}, {3'b101, 7'b0001111, 1'b0});

        // reset during a D1 slot while blink phase is 1: phase must restart
        reset = 1'b1;
        tick("rst_a");
        reset = 1'b0;
        d0 = 4'd8; d1 = 4'd1; d2 = 4'd2; par = 3'b001;
        while (n_m < 80) tick("pre_rst");
        reset = 1'b1;
        tick("rst_mid");
        chk("rst_mid_out", {an, seg, fin}, {3'b111, 7'b1111111, 1'b0});
        reset = 1'b0;
        tick("rst_rel");
        chk("rst_rel_d0", {an, seg, fin}, {3'b110, 7'b0000000, 1'b0});

        // blink sequence from a clean reset
        reset = 1'b1;
        tick("rst_b");
        reset = 1'b0;
        while (n_m < 160) begin
            tick("blink");
            if (n_m == 73) chk("blink_73", {an, seg, fin}, {3'b110, 7'b0000000, 1'b0});
            if (n_m == 76) chk("blink_76", {an, seg, fin}, {3'b110, 7'b1111111, 1'b0});
            if (n_m == 77) chk("blink_77_d1", {an, seg, fin}, {3'b101, 7'b1001111, 1'b0});
            if (n_m == 151) chk("blink_151", {an, seg, fin}, {3'b110, 7'b0000000, 1'b0});
        end

        // randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            d0 = 4'($urandom_range(0, 15));
            d1 = 4'($urandom_range(0, 15));
            d2 = 4'($urandom_range(0, 15));
            par = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 59) == 0);
            tick("random");
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
